// File: rtl/shared_reg_arbiter.sv
// Two-requester round-robin arbiter guarding one shared storage register.
// Each access runs IDLE -> ACCESS -> DONE, so a requester gets one access per three cycles.
module shared_reg_arbiter #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             wr0,
    input  logic             wr1,
    input  logic [width-1:0] wdata0,
    input  logic [width-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack0,
    output logic             ack1,
    output logic [width-1:0] read_data,
    output logic             busy
);

    // state  | meaning
    // IDLE   | no owner; arbitrate on any request
    // ACCESS | owner's latched op commits on the exit edge
    // DONE   | owner's ack is high; last_grant updates on the exit edge
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]       r_state;
    logic             r_last_grant;
    logic             r_owner;
    logic             r_wr;
    logic [width-1:0] r_wdata;
    logic [width-1:0] r_storage;
    logic [width-1:0] r_read_data;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_ack0;
    logic             r_ack1;

    logic             w_winner;

    // On a tie the requester not served most recently wins.
    assign w_winner = (req0 && req1) ? !r_last_grant : req1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_wr         <= 1'b0;
            r_wdata      <= '0;
            r_storage    <= '0;
            r_read_data  <= '0;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        r_owner <= w_winner;
                        r_wr    <= w_winner ? wr1 : wr0;
                        r_wdata <= w_winner ? wdata1 : wdata0;
                        r_gnt0  <= !w_winner;
                        r_gnt1  <= w_winner;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_wr) begin
                        r_storage <= r_wdata;
                    end else begin
                        r_read_data <= r_storage;
                    end
                    r_ack0  <= !r_owner;
                    r_ack1  <= r_owner;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_ack0       <= 1'b0;
                    r_ack1       <= 1'b0;
                    r_gnt0       <= 1'b0;
                    r_gnt1       <= 1'b0;
                    r_last_grant <= r_owner;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign read_data = r_read_data;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter; inputs driven and outputs sampled 1 ns after each rising edge.
module tb_shared_reg_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, wr0, wr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, ack0, ack1, busy;
    logic [31:0] read_data;

    int checks = 0;
    int errors = 0;

    shared_reg_arbiter #(.width(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .wr0       (wr0),
        .wr1       (wr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .ack0      (ack0),
        .ack1      (ack1),
        .read_data (read_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access by requester `who`; read_data is checked in the ack cycle.
    task automatic run_op(input bit who, input logic wr, input logic [31:0] wd,
                          input logic [31:0] exp_rd);
        logic [31:0] sel;
        sel = who ? 32'd2 : 32'd1;
        if (who) begin
            req1 = 1'b1; wr1 = wr; wdata1 = wd;
        end else begin
            req0 = 1'b1; wr0 = wr; wdata0 = wd;
        end
        tick();
        check_val("op_gnt_access", {30'd0, gnt1, gnt0}, sel);
        check_val("op_ack_access", {30'd0, ack1, ack0}, 32'd0);
        check_val("op_busy_access", {31'd0, busy}, 32'd1);
        tick();
        check_val("op_gnt_done", {30'd0, gnt1, gnt0}, sel);
        check_val("op_ack_done", {30'd0, ack1, ack0}, sel);
        check_val("op_rdata", read_data, exp_rd);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        check_val("op_gnt_idle", {30'd0, gnt1, gnt0}, 32'd0);
        check_val("op_ack_idle", {30'd0, ack1, ack0}, 32'd0);
        check_val("op_busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        wdata0 = '0; wdata1 = '0;
        tick();
        tick();
        check_val("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        check_val("rst_ack", {30'd0, ack1, ack0}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_rdata", read_data, 32'd0);
        rst = 1'b0;
        tick();
        check_val("idle_no_req_busy", {31'd0, busy}, 32'd0);

        // First read after reset, then write by 1 and read back by 0.
        run_op(1'b0, 1'b0, 32'h0, 32'h0000_0000);
        run_op(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000);
        run_op(1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);

        // Both requests held from reset; rst wins the edge where they first appear.
        rst = 1'b1;
        req0 = 1'b1; wr0 = 1'b1; wdata0 = 32'h11;
        req1 = 1'b1; wr1 = 1'b1; wdata1 = 32'h22;
        tick();
        check_val("rst_prio_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        check_val("rst_prio_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("rr_gnt", {30'd0, gnt1, gnt0}, (i % 2 == 0) ? 32'd1 : 32'd2);
            check_val("rr_ack_early", {30'd0, ack1, ack0}, 32'd0);
            tick();
            check_val("rr_ack", {30'd0, ack1, ack0}, (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            check_val("rr_idle_busy", {31'd0, busy}, 32'd0);
            check_val("rr_idle_ack", {30'd0, ack1, ack0}, 32'd0);
        end
        req0 = 1'b0; req1 = 1'b0;
        run_op(1'b0, 1'b0, 32'h0, 32'h0000_0022);

        // Inputs changed and req dropped during ACCESS must not alter the write.
        req0 = 1'b1; wr0 = 1'b1; wdata0 = 32'h55;
        tick();
        check_val("late_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        req0 = 1'b0; wr0 = 1'b0; wdata0 = 32'hAA;
        tick();
        check_val("late_ack", {30'd0, ack1, ack0}, 32'd1);
        tick();
        check_val("late_idle_busy", {31'd0, busy}, 32'd0);
        run_op(1'b1, 1'b0, 32'h0, 32'h0000_0055);

        // Reset during ACCESS of a write aborts it.
        req0 = 1'b1; wr0 = 1'b1; wdata0 = 32'h77;
        tick();
        check_val("abort_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        rst = 1'b1; req0 = 1'b0;
        tick();
        check_val("abort_ack", {30'd0, ack1, ack0}, 32'd0);
        check_val("abort_gnt_clr", {30'd0, gnt1, gnt0}, 32'd0);
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_rdata", read_data, 32'd0);
        rst = 1'b0;
        tick();
        check_val("abort_no_ack", {30'd0, ack1, ack0}, 32'd0);
        run_op(1'b0, 1'b0, 32'h0, 32'h0000_0000);

        // req1 arriving during req0's ACCESS waits and is granted right after IDLE.
        req0 = 1'b1; wr0 = 1'b1; wdata0 = 32'h33;
        tick();
        check_val("wait_busy_access", {31'd0, busy}, 32'd1);
        req1 = 1'b1; wr1 = 1'b0;
        tick();
        check_val("wait_gnt_done", {30'd0, gnt1, gnt0}, 32'd1);
        check_val("wait_ack0", {30'd0, ack1, ack0}, 32'd1);
        req0 = 1'b0;
        tick();
        check_val("wait_idle_busy", {31'd0, busy}, 32'd0);
        check_val("wait_idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        tick();
        check_val("wait_gnt1", {30'd0, gnt1, gnt0}, 32'd2);
        check_val("wait_busy1", {31'd0, busy}, 32'd1);
        tick();
        check_val("wait_ack1", {30'd0, ack1, ack0}, 32'd2);
        check_val("wait_rdata", read_data, 32'h0000_0033);
        req1 = 1'b0;
        tick();
        check_val("wait_end_busy", {31'd0, busy}, 32'd0);

        // read_data holds across a later write.
        run_op(1'b1, 1'b1, 32'h9999_0000, 32'h0000_0033);
        check_val("rdata_hold", read_data, 32'h0000_0033);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Structural invariants checked every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt0 && gnt1) check_val("both_gnt", {30'd0, gnt1, gnt0}, 32'd0);
            if (ack0 && ack1) check_val("both_ack", {30'd0, ack1, ack0}, 32'd0);
            if (ack0 && !gnt0) check_val("ack0_no_gnt", {31'd0, gnt0}, 32'd1);
            if (ack1 && !gnt1) check_val("ack1_no_gnt", {31'd0, gnt1}, 32'd1);
        end
    end

endmodule
